// File: rtl/counter_capture.sv
// Timestamps capture/match events against a free-running count and queues
// them in a small FIFO drained over a valid/ready interface.
module counter_capture #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       cap_req,
  input  logic                       match_en,
  input  logic [WIDTH-1:0]           match_val,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH+2:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = WIDTH + 3;

  typedef struct packed {
    logic             match;
    logic             req;
    logic             wrap;
    logic [WIDTH-1:0] count;
  } entry_t;

  logic [WIDTH-1:0] prev_cnt;
  logic             wrap_pend;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  entry_t           mem [DEPTH];

  logic             match_hit;
  logic             wrap_now;
  logic             evt;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  entry_t           new_entry;
  entry_t           head_next;
  logic [AW-1:0]    wr_next;
  logic [AW-1:0]    rd_next;
  logic [LW-1:0]    level_next;
  logic             valid_next;
  logic [DW-1:0]    data_next;
  logic             wrap_pend_next;
  logic             ovf_next;

  // Event detection, FIFO bookkeeping and next head entry
  always_comb begin
    match_hit      = 1'b0;
    wrap_now       = 1'b0;
    evt            = 1'b0;
    full           = 1'b0;
    pop            = 1'b0;
    push           = 1'b0;
    drop           = 1'b0;
    new_entry      = '0;
    head_next      = '0;
    wr_next        = wr_ptr;
    rd_next        = rd_ptr;
    level_next     = level;
    valid_next     = 1'b0;
    data_next      = '0;
    wrap_pend_next = wrap_pend;
    ovf_next       = ovf;

    // A held count produces only one hit: require the previous count to differ
    match_hit = match_en & (count_in == match_val) & (prev_cnt != match_val);
    wrap_now  = (count_in < prev_cnt);
    evt       = cap_req | match_hit;
    full      = (level == LW'(DEPTH));
    pop       = out_valid & out_ready;
    push      = evt & (~full | pop);
    drop      = evt & full & ~pop;

    new_entry.match = match_hit;
    new_entry.req   = cap_req;
    new_entry.wrap  = wrap_pend | wrap_now;
    new_entry.count = count_in;

    if (push) wr_next = wr_ptr + AW'(1);
    if (pop)  rd_next = rd_ptr + AW'(1);

    unique case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase

    // Write-through when the slot being written becomes the new head
    if (push && (wr_ptr == rd_next)) head_next = new_entry;
    else                             head_next = mem[rd_next];

    valid_next = (level_next != '0);
    data_next  = valid_next ? DW'(head_next) : '0;

    // A dropped event keeps the pending wrap for the next stored entry
    if (push) wrap_pend_next = 1'b0;
    else      wrap_pend_next = wrap_pend | wrap_now;

    // Set has priority over clear
    if (drop)         ovf_next = 1'b1;
    else if (clr_ovf) ovf_next = 1'b0;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt  <= '0;
      wrap_pend <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      prev_cnt  <= count_in;
      wrap_pend <= wrap_pend_next;
      wr_ptr    <= wr_next;
      rd_ptr    <= rd_next;
      level     <= level_next;
      ovf       <= ovf_next;
      out_valid <= valid_next;
      out_data  <= data_next;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

endmodule

// File: doc/counter_capture.md
# counter_capture

Downstream consumer of the 6-bit free-running counter. Timestamps events against the live count value and buffers them in a small FIFO drained over a valid/ready interface. An event is either a software capture request or a count match. Each entry also records whether the counter wrapped since the last stored entry.

## Interface
- WIDTH, 6, width of the count input
- DEPTH, 8, FIFO entries; power of two, ≥2
- clk  input  1  rising-edge clock shared with the counter
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- count_in  input  WIDTH  live counter value
- cap_req  input  1  capture request, sampled each cycle
- match_en  input  1  enables match events
- match_val  input  WIDTH  count value that generates a match event
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  WIDTH+3  {match, req, wrap, count[WIDTH-1:0]}
- level  output  log2(DEPTH)+1  entries stored
- ovf  output  1  sticky overflow flag
- clr_ovf  input  1  clears ovf

## Operation
- prev_cnt register holds count_in from the previous cycle; resets to 0.
- match_hit = match_en & (count_in == match_val) & (prev_cnt != match_val). A held counter produces exactly one hit.
- wrap_now = (count_in < prev_cnt).
- wrap_pend is set by wrap_now and cleared by an accepted push.
- event = cap_req | match_hit. If both are true, one entry is produced with match=1 and req=1.
- Entry fields:
  - count = count_in in the event cycle.
  - wrap = wrap_pend | wrap_now.
- pop = out_valid & out_ready.
- push accepted = event & (level < DEPTH | pop). A push is accepted when full if a pop happens in the same cycle.
- Dropped event (event & full & !pop):
  - ovf is set.
  - wrap_pend is retained, so the next accepted entry still reports the wrap.
- ovf is cleared by clr_ovf. If set and clear occur in the same cycle, set wins.
- FIFO:
  - Circular buffer with read and write pointers of log2(DEPTH) bits; wrap-around is natural.
  - level tracks occupancy: +1 on push only, -1 on pop only, unchanged on both.
- out_data shows the head entry. It is forced to all zeros when out_valid=0.
- out_valid = (level != 0).

## Timing
- Reset (rst=0, asynchronous, any time):
  - out_valid=0, level=0, ovf=0, out_data=0.
  - prev_cnt=0, wrap_pend=0, both pointers 0.
  - Stored entries are discarded, including mid-drain.
- Event in cycle N is written at the rising edge ending cycle N. out_valid=1 in cycle N+1 (latency 1).
- Pop takes effect at the edge where out_valid & out_ready. The next entry (or out_valid=0) is visible the following cycle.
- No combinational path from out_ready to out_valid or out_data.
- level and ovf are registered and reflect edges up to and including the previous edge.

## Test plan
- **Match event.** Counter released from reset, match_en=1, match_val=5, out_ready=1.
  - Response: one entry 0x105 (match=1, req=0, wrap=0, count=5), out_valid high for exactly 1 cycle.
- **Wrap flag.** match_val=2; let the counter pass 63→0→2.
  - Response: entry 0x142 (wrap=1, count=2). A subsequent cap_req at count 10 yields 0x08A (wrap cleared).
- **Overflow.** out_ready=0; cap_req held high for 10 cycles starting at count 20.
  - Response: level=8, ovf=1; entries 0x094…0x09B (counts 20–27).
  - Then clr_ovf pulse → ovf=0; draining returns those 8 in order, then out_valid=0.
- **Simultaneous push/pop at full.** FIFO full (level=8), out_ready=1 with cap_req=1 for one cycle.
  - Response: level stays 8, ovf stays 0, new entry appears last.
- **Coincident sources.** cap_req=1 in the cycle count hits match_val=12.
  - Response: single entry 0x18C (match=1, req=1); level increments by 1.
- **Reset mid-operation.** Pulse rst low for 3 ns (not clock-aligned) with level=5, ovf=1.
  - Response: out_valid, level, ovf and out_data go to 0 immediately.
  - After release, the first match entry behaves as in the match-event scenario.
